// File: rtl/hssdrc_arb_pkg.sv
// Shared types and width constants for the HSSDRC system-interface arbiter.
package hssdrc_arb_pkg;

    typedef logic [11:0] rowa_t;
    typedef logic [8:0]  cola_t;
    typedef logic [1:0]  ba_t;
    typedef logic [1:0]  burst_t;
    typedef logic [2:0]  chid_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  datam_t;

    localparam int unsigned ROWA_W  = $bits(rowa_t);
    localparam int unsigned COLA_W  = $bits(cola_t);
    localparam int unsigned BA_W    = $bits(ba_t);
    localparam int unsigned BURST_W = $bits(burst_t);
    localparam int unsigned CHID_W  = $bits(chid_t);
    localparam int unsigned DATA_W  = $bits(data_t);
    localparam int unsigned DATAM_W = $bits(datam_t);

    // Owner of an accepted write: whose data to fetch and for how many words.
    typedef struct packed {
        chid_t  chid;
        burst_t burst;
    } owner_t;

    typedef struct packed {
        logic   write;
        logic   read;
        logic   refr;
        rowa_t  rowa;
        cola_t  cola;
        ba_t    ba;
        burst_t burst;
        chid_t  chid;
    } cmd_t;

    typedef enum logic {
        CMD_EMPTY = 1'b0,
        CMD_FULL  = 1'b1
    } cmd_state_e;

endpackage

// File: rtl/hssdrc_arb_owner_fifo.sv
// Synchronous FIFO of write owners; push and pop may coincide at any occupancy.
module hssdrc_arb_owner_fifo
    import hssdrc_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  owner_t           din_i,
    output owner_t           head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    owner_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (sclr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/hssdrc_sys_arbiter.sv
// Round-robin arbiter sharing the HSSDRC system command port between client channels
// and refresh. Optional macro HSSDRC_ARB_CH0_PRIO_EN gives channel 0 strict priority.
module hssdrc_sys_arbiter
    import hssdrc_arb_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned WFIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sclr,
    input  logic [NUM_CH-1:0]           ch_req,
    input  logic [NUM_CH-1:0]           ch_write,
    input  logic [NUM_CH-1:0]           ch_read,
    input  logic [NUM_CH*ROWA_W-1:0]    ch_rowa,
    input  logic [NUM_CH*COLA_W-1:0]    ch_cola,
    input  logic [NUM_CH*BA_W-1:0]      ch_ba,
    input  logic [NUM_CH*BURST_W-1:0]   ch_burst,
    output logic [NUM_CH-1:0]           ch_ack,
    input  logic [NUM_CH*DATA_W-1:0]    ch_wdata,
    input  logic [NUM_CH*DATAM_W-1:0]   ch_wdatam,
    output logic [NUM_CH-1:0]           ch_use_wdata,
    output logic [NUM_CH-1:0]           ch_vld_rdata,
    output logic [DATA_W-1:0]           ch_rdata,
    input  logic                        ref_req,
    output logic                        ref_ack,
    output logic                        sys_write,
    output logic                        sys_read,
    output logic                        sys_refr,
    output logic [ROWA_W-1:0]           sys_rowa,
    output logic [COLA_W-1:0]           sys_cola,
    output logic [BA_W-1:0]             sys_ba,
    output logic [BURST_W-1:0]          sys_burst,
    output logic [CHID_W-1:0]           sys_chid_i,
    output logic [DATA_W-1:0]           sys_wdata,
    output logic [DATAM_W-1:0]          sys_wdatam,
    input  logic                        sys_ready,
    input  logic                        sys_use_wdata,
    input  logic                        sys_vld_rdata,
    input  logic [CHID_W-1:0]           sys_chid_o,
    input  logic [DATA_W-1:0]           sys_rdata,
    output logic                        err
);

    localparam int unsigned PTR_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(WFIFO_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    cmd_state_e       state_q, state_d;
    cmd_t             cmd_q, cmd_d, new_cmd;
    logic [PTR_W-1:0] ptr_q, ptr_d, winner;
    burst_t           wcnt_q, wcnt_d;
    logic             err_q, err_d;

    logic             active, accept, can_load, grant, ref_gnt, found, ch0_hit;
    logic             reg_wr, write_ok, wd_active, wd_last, vld_bad;
    logic [NUM_CH-1:0] eligible;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    owner_t           fifo_head;
    logic [CNT_W-1:0] fifo_count;

    assign active   = reset & ~sclr;
    assign accept   = (state_q == CMD_FULL) & sys_ready;
    assign can_load = active & ((state_q == CMD_EMPTY) | accept);

    hssdrc_arb_owner_fifo #(.DEPTH(WFIFO_DEPTH)) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .sclr_i  (sclr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ('{chid: cmd_q.chid, burst: cmd_q.burst}),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_push = active & accept & cmd_q.write;
    assign wd_active = active & sys_use_wdata & ~fifo_empty;
    assign wd_last   = (wcnt_q == fifo_head.burst);
    assign fifo_pop  = wd_active & wd_last;

    // A write held in the register already owns a FIFO slot; a pop this cycle returns one.
    assign reg_wr   = (state_q == CMD_FULL) & cmd_q.write;
    assign write_ok = (OCC_W'(fifo_count) + OCC_W'(reg_wr)) < (OCC_W'(WFIFO_DEPTH) + OCC_W'(fifo_pop));
    assign eligible = ch_req & ~(ch_write & {NUM_CH{~write_ok}});

    always_comb begin
        ref_gnt = 1'b0;
        found   = 1'b0;
        ch0_hit = 1'b0;
        winner  = '0;
        if (can_load) begin
            if (ref_req) begin
                ref_gnt = 1'b1;
            end else begin
`ifdef HSSDRC_ARB_CH0_PRIO_EN
                if (eligible[0]) begin
                    found   = 1'b1;
                    ch0_hit = 1'b1;
                end
`endif
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (!found && eligible[PTR_W'((32'(ptr_q) + i) % NUM_CH)]) begin
                        found  = 1'b1;
                        winner = PTR_W'((32'(ptr_q) + i) % NUM_CH);
                    end
                end
            end
        end
    end

    assign grant   = ref_gnt | found;
    assign ref_ack = ref_gnt;
    assign ch_ack  = found ? (NUM_CH'(1) << winner) : '0;

    // Build the winning command; a refresh leaves every field but refr at zero.
    always_comb begin
        new_cmd = '0;
        if (ref_gnt) begin
            new_cmd.refr = 1'b1;
        end else if (found) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (PTR_W'(c) == winner) begin
                    new_cmd.write = ch_write[c];
                    new_cmd.read  = ch_read[c] & ~ch_write[c];
                    new_cmd.rowa  = ch_rowa[c*ROWA_W +: ROWA_W];
                    new_cmd.cola  = ch_cola[c*COLA_W +: COLA_W];
                    new_cmd.ba    = ch_ba[c*BA_W +: BA_W];
                    new_cmd.burst = ch_burst[c*BURST_W +: BURST_W];
                    new_cmd.chid  = CHID_W'(c);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            CMD_EMPTY: begin
                if (grant) begin
                    state_d = CMD_FULL;
                    cmd_d   = new_cmd;
                end
            end
            CMD_FULL: begin
                if (accept) begin
                    if (grant) begin
                        cmd_d = new_cmd;
                    end else begin
                        state_d = CMD_EMPTY;
                        cmd_d   = '0;
                    end
                end
            end
            default: begin
                state_d = CMD_EMPTY;
                cmd_d   = '0;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found && !ch0_hit) begin
            ptr_d = (winner == PTR_W'(NUM_CH - 1)) ? '0 : winner + PTR_W'(1);
        end
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (wd_active) begin
            wcnt_d = wd_last ? '0 : wcnt_q + BURST_W'(1);
        end
    end

    assign vld_bad = sys_vld_rdata & (32'(sys_chid_o) >= NUM_CH);

    always_comb begin
        err_d = err_q;
        if (active && ((|(ch_req & ch_write & ch_read)) ||
                       (sys_use_wdata && fifo_empty) || vld_bad ||
                       (fifo_push && fifo_full && !fifo_pop))) begin
            err_d = 1'b1;
        end
    end

    // Data steering: write data follows the FIFO head, read strobe follows sys_chid_o.
    always_comb begin
        ch_use_wdata = '0;
        ch_vld_rdata = '0;
        sys_wdata    = '0;
        sys_wdatam   = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (active && !fifo_empty && fifo_head.chid == CHID_W'(c)) begin
                sys_wdata       = ch_wdata[c*DATA_W +: DATA_W];
                sys_wdatam      = ch_wdatam[c*DATAM_W +: DATAM_W];
                ch_use_wdata[c] = sys_use_wdata;
            end
            if (active && sys_vld_rdata && sys_chid_o == CHID_W'(c)) begin
                ch_vld_rdata[c] = 1'b1;
            end
        end
    end

    assign ch_rdata = sys_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CMD_EMPTY;
            cmd_q   <= '0;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else if (sclr) begin
            state_q <= CMD_EMPTY;
            cmd_q   <= '0;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign sys_write  = cmd_q.write;
    assign sys_read   = cmd_q.read;
    assign sys_refr   = cmd_q.refr;
    assign sys_rowa   = cmd_q.rowa;
    assign sys_cola   = cmd_q.cola;
    assign sys_ba     = cmd_q.ba;
    assign sys_burst  = cmd_q.burst;
    assign sys_chid_i = cmd_q.chid;
    assign err        = err_q;

endmodule

// File: doc/hssdrc_sys_arbiter.md
Name: hssdrc_sys_arbiter

Overview:
Shares the single HSSDRC system command interface between NUM_CH requesters plus one refresh requester. Arbitration is round-robin; the command is held in a one-entry register until the controller accepts it. The block tags each command with the channel id on sys_chid_i. It routes use_wdata, write data, vld_rdata and read data back to the owning channel. It sits between the client ports and the hssdrc core, and drives the core's system-interface slave side.

Parameters:
NUM_CH, 4, number of client channels (2..2**CHID_W)
WFIFO_DEPTH, 4, outstanding-write owner FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sclr  in  1  synchronous clear, active-high, same effect as reset
ch_req  in  NUM_CH  per-channel command request, level, held until ch_ack
ch_write/ch_read  in  NUM_CH each  command type; exactly one set while ch_req is high
ch_rowa/ch_cola/ch_ba/ch_burst  in  NUM_CH*ROWA_W/COLA_W/BA_W/BURST_W  flattened address/burst
ch_ack  out  NUM_CH  one-cycle pulse when the channel's command is loaded into the register
ch_wdata/ch_wdatam  in  NUM_CH*DATA_W / NUM_CH*DATAM_W  per-channel write data/mask
ch_use_wdata  out  NUM_CH  routed use_wdata strobe
ch_vld_rdata  out  NUM_CH  routed vld_rdata strobe
ch_rdata  out  DATA_W  broadcast read data (sys_rdata, passed through)
ref_req  in  1  refresh request, level; ref_ack  out  1  one-cycle pulse on load
sys_write/sys_read/sys_refr/sys_rowa/sys_cola/sys_ba/sys_burst/sys_chid_i  out  pkg widths  registered command to core
sys_wdata/sys_wdatam  out  DATA_W/DATAM_W  write data muxed by FIFO head owner
sys_ready/sys_use_wdata/sys_vld_rdata/sys_chid_o/sys_rdata  in  pkg widths  core responses
err  out  1  sticky protocol error flag

Behaviour:
- Reset/sclr: all outputs 0, command register empty, RR pointer 0, FIFO empty, err 0.
- Command register FSM: EMPTY -> FULL on grant. FULL -> EMPTY on sys_ready & valid with no new grant. FULL -> FULL (reload) on accept plus a new grant in the same cycle. Zero-bubble back-to-back operation is required.
- Grant occurs when the register is EMPTY or being accepted this cycle.
- Grant priority: ref_req first, then round-robin over eligible ch_req starting at the RR pointer.
- After a channel grant, pointer = winner+1 mod NUM_CH. A refresh grant does not move the pointer.
- A channel is eligible unless it requests a write while the FIFO is full or becomes full this cycle (count + pending uncommitted writes == WFIFO_DEPTH). Reads and refresh are never blocked by the FIFO.
- Ack/load latency: ch_ack pulses in the grant cycle. sys_* is valid from the next cycle and held stable until sys_ready.
- Refresh commands carry chid_i = 0, burst = 0, and unused address fields = 0.
- On accept of a write (sys_ready & sys_write), push {chid, burst} to the owner FIFO.
- Each sys_use_wdata cycle: assert ch_use_wdata[head.chid] combinationally, drive sys_wdata/sys_wdatam from that channel, and increment the word counter.
- When the word counter reaches head.burst, pop the FIFO and clear the counter. Burst value b means b+1 words.
- sys_use_wdata while the FIFO is empty: no ch strobe, and err is set.
- Simultaneous push and pop is legal at any occupancy, including full (the pop frees the slot).
- sys_vld_rdata: ch_vld_rdata[sys_chid_o] = 1, combinationally. If sys_chid_o >= NUM_CH, the strobe is dropped and err is set.
- err is set if ch_write & ch_read are both high on a requesting channel. That channel is still arbitrated, and write takes precedence.
- Reset mid-burst: FIFO, counter and register are discarded, with no outputs driven afterward.

Optional Feature:
HSSDRC_ARB_CH0_PRIO_EN.
- Defined: channel 0 has strict priority over the round-robin channels, but still ranks below refresh. A channel 0 grant does not move the pointer.
- Undefined: pure round-robin as above.

Decomposition:
- Package hssdrc_arb_pkg holds owner_t {chid_t chid; burst_t burst;} and the width constants ROWA_W, COLA_W, BA_W, BURST_W, CHID_W, DATA_W, DATAM_W, all derived from the existing rowa_t/cola_t/ba_t/burst_t/chid_t/data_t/datam_t.
- One natural sub-module: hssdrc_arb_owner_fifo, a synchronous FIFO of owner_t with full/empty/count outputs.

Test Plan:
- ch_req=4'b1111, all reads, sys_ready=1 -> grants in order 0,1,2,3,0, one per cycle; sys_chid_i follows 0,1,2,3 with no bubbles.
- ref_req with ch_req[2], register empty -> ref_ack first, sys_refr=1 with chid 0; ch 2 is granted on the next load.
- Write ch1 burst=3, then read ch3 -> four sys_use_wdata pulses map to ch_use_wdata[1] and sys_wdata=ch1 data; the FIFO then pops.
- Four writes outstanding (FIFO full) plus a read on another channel -> the read is granted and the fifth write is stalled. The write is granted in the cycle its slot frees on the pop.
- sys_vld_rdata with sys_chid_o=2 -> ch_vld_rdata=4'b0100. With sys_chid_o=5 and NUM_CH=4 -> no strobe and err=1.
- Assert reset low while sys_write is waiting on sys_ready=0 -> all outputs 0 immediately; after release, no stale use_wdata routing occurs.
